// File: rtl/spi_ao_master.sv
// SPI mode-0 master sending one 48-bit orientation frame {teta0, phi0}, MSB first,
// with chip select held low across all six bytes and a minimum CS-high gap afterwards.
module spi_ao_master #(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter int CS_IDLE_CLKS      = 2
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_Start,
   input  logic [23:0] i_Teta0,
   input  logic [23:0] i_Phi0,
   output logic        o_Ready,
   output logic        o_Done,
   output logic        o_SPI_Clk,
   output logic        o_SPI_MOSI,
   output logic        o_SPI_CS_n
);

   localparam int MAX_CNT = (CLKS_PER_HALF_BIT > CS_IDLE_CLKS) ? CLKS_PER_HALF_BIT : CS_IDLE_CLKS;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_IDLE_CLKS - 1);
   localparam logic [5:0]       LAST_BIT  = 6'd47;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [47:0]       shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]        bit_q, bit_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              mosi_q, mosi_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              frame_active;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // cnt_q is shared: setup/hold length, half-period timer in SHIFT, and the CS gap.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;

      unique case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b0;
            cnt_d  = '0;
            bit_d  = '0;
            if (i_Start) begin
               shift_d = {i_Teta0, i_Phi0};
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_SHIFT: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  // The last falling edge does not shift, so MOSI keeps bit 0 through HOLD.
                  if (bit_q == LAST_BIT) begin
                     state_d = ST_HOLD;
                  end else begin
                     shift_d = {shift_q[46:0], 1'b0};
                     bit_d   = bit_q + 6'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_HOLD: begin
            sclk_d = 1'b0;
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            sclk_d = 1'b0;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered so the pins never glitch.
   always_comb begin
      frame_active = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
      cs_n_d       = !frame_active;
      mosi_d       = frame_active ? shift_d[47] : 1'b0;
      ready_d      = (state_d == ST_IDLE);
      done_d       = (state_d == ST_GAP) && (cnt_d == GAP_LAST);
   end

   assign o_Ready    = ready_q;
   assign o_Done     = done_q;
   assign o_SPI_Clk  = sclk_q;
   assign o_SPI_MOSI = mosi_q;
   assign o_SPI_CS_n = cs_n_q;

endmodule

// File: doc/spi_ao_master.md
Name: spi_ao_master

Overview:
- SPI mode-0 master that transmits one orientation frame (teta0, phi0; 24 bits each) to the AO-reception SPI slave.
- It is the transmit end of the AO angle link. Used on the AO/host-emulation side and in board loopback tests, driving SPIclk/SPIdat/SPIss.
- The frame is 6 bytes, MSB first, with chip select held low for the whole frame.

Parameters:
- CLKS_PER_HALF_BIT, 4, i_Clk cycles per SCLK half-period (H); legal range ≥2.
- CS_IDLE_CLKS, 2, minimum i_Clk cycles CS stays high between frames (I); legal range ≥1.

Ports:
- i_Clk  input  1  system clock
- i_Rst_n  input  1  asynchronous active-low reset
- i_Start  input  1  one-cycle frame request; accepted only when o_Ready=1
- i_Teta0  input  24  elevation angle, fixed-point; sampled on accepted i_Start
- i_Phi0  input  24  azimuth angle, fixed-point; sampled on accepted i_Start
- o_Ready  output  1  high when idle and able to accept i_Start
- o_Done  output  1  one-cycle pulse when a frame has completed, including the CS gap
- o_SPI_Clk  output  1  SCLK, CPOL=0
- o_SPI_MOSI  output  1  serial data, CPHA=0
- o_SPI_CS_n  output  1  chip select, active low

Behaviour:
- Reset values (asynchronous, while i_Rst_n=0): o_Ready=1, o_Done=0, o_SPI_Clk=0, o_SPI_MOSI=0, o_SPI_CS_n=1, state=IDLE, shift register=0, all counters=0.
- Reset mid-frame: outputs return immediately to the reset values. No o_Done is generated for the aborted frame.
- Shift register: 48 bits, loaded as {i_Teta0, i_Phi0} on an accepted start. Bit 47 is transmitted first, so the byte order is teta0[23:16], teta0[15:8], teta0[7:0], phi0[23:16], phi0[15:8], phi0[7:0].
- Inputs are latched on acceptance. Later changes to i_Teta0/i_Phi0 do not affect the frame in flight.
- i_Start is ignored while o_Ready=0. It is not queued.

State machine:
- IDLE:
  - o_Ready=1, CS_n=1, SCLK=0.
  - On i_Start: latch data, go to SETUP.
  - o_Ready drops on the cycle after acceptance.
- SETUP (H cycles):
  - CS_n=0, MOSI=bit47, SCLK=0.
  - Gives H cycles of CS-to-first-edge setup.
- SHIFT (96 half-periods, H cycles each):
  - Half-period counter wraps at H-1; SCLK toggles on each wrap.
  - Rising edge: the slave samples; MOSI is held.
  - Falling edge: shift left; MOSI takes the next bit.
  - After the 48th falling edge, SCLK=0; go to HOLD.
  - Bit counter runs 0..47 and does not wrap past 47.
- HOLD (H cycles):
  - CS_n=0, SCLK=0, MOSI holds its last value.
- GAP (I cycles):
  - CS_n=1, MOSI=0.
  - On the last GAP cycle, o_Done=1 for one cycle; next state is IDLE.
  - o_Ready=1 on the cycle after o_Done.

Timing:
- i_Start in cycle 0 → CS_n falls in cycle 1.
- First SCLK rise at cycle 1+2H.
- o_Done at cycle H+96H+H+I.
- For H=4, I=2, o_Done is at cycle 394.
- SCLK frequency = f(i_Clk)/(2H). No SCLK edges occur outside SHIFT.
- Back-to-back frames: i_Start held high is re-accepted in the first IDLE cycle. Minimum CS-high time is I+1 cycles.

Test Plan:
- Reset, then Teta0=0x123456, Phi0=0xABCDEF, one i_Start → a behavioural SPI slave sampling on rising edges captures bytes 12 34 56 AB CD EF; o_Done fires exactly once at cycle 394 (H=4, I=2); 48 SCLK rising edges are counted.
- Protocol checks: MOSI is stable during SCLK-high; CS_n falls ≥H cycles before the first rise; CS_n rises ≥H cycles after the last fall; SCLK=0 whenever CS_n=1.
- i_Start pulsed again at cycle 100 with Phi0=0x000001 → ignored; the frame still sends ABCDEF; only one o_Done; inputs changed mid-frame do not alter output.
- i_Start held high for two frames (0xFFFFFF/0x000000, then 0x800000/0x000001) → two correct frames; CS_n high for ≥3 cycles between them; two o_Done pulses.
- i_Rst_n asserted at cycle 200 → CS_n=1, SCLK=0, MOSI=0 immediately; no o_Done; after release, o_Ready=1 and a new frame transmits correctly.
- CLKS_PER_HALF_BIT=2, CS_IDLE_CLKS=1 → SCLK period is 4 cycles; o_Done at cycle 2+192+2+1=197; data is correct.
